// File: rtl/arcrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arcrypt_pkg
// Description : Shared widths, FIFO entry type and Control op-code constants
//               for the arithmetic crypto core and its result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package arcrypt_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;

    // One buffered result: op tag in the upper bits, core result below.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } arcrypt_entry_t;

    // Control op codes understood by the core.
    localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
    localparam logic [OP_W-1:0] OP_MUL    = 4'h2;
    localparam logic [OP_W-1:0] OP_XOR    = 4'h3;
    localparam logic [OP_W-1:0] OP_AND    = 4'h4;
    localparam logic [OP_W-1:0] OP_OR     = 4'h5;
    localparam logic [OP_W-1:0] OP_ROTL   = 4'h6;
    localparam logic [OP_W-1:0] OP_ROTR   = 4'h7;
    localparam logic [OP_W-1:0] OP_MODADD = 4'h8;
    localparam logic [OP_W-1:0] OP_MODMUL = 4'h9;

endpackage : arcrypt_pkg
`default_nettype wire

// File: rtl/arcrypt_issue_delay.sv
`default_nettype none
// ============================================================================
// Module      : arcrypt_issue_delay
// Description : CORE_LATENCY-stage {valid, op} shift pipeline that follows
//               each issued operation through the core pipeline.
//               Stage 0 loads the input every cycle; there are no stalls.
// Ports       : clk, rst        - clock, synchronous active-high clear
//               in_valid/in_op  - issue strobe and op tag entering stage 0
//               last_valid/op   - contents of the final stage
// Revision    : 1.0 - initial release
// ============================================================================
module arcrypt_issue_delay
    import arcrypt_pkg::*;
#(
    parameter int CORE_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [OP_W-1:0] in_op,
    output logic            last_valid,
    output logic [OP_W-1:0] last_op
);

    logic [CORE_LATENCY-1:0] r_valid;
    logic [OP_W-1:0]         r_op [CORE_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < CORE_LATENCY; i++) begin
                r_op[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_op[0]    <= in_op;
            // Loop is empty when CORE_LATENCY == 1.
            for (int i = 1; i < CORE_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_op[i]    <= r_op[i-1];
            end
        end
    end

    assign last_valid = r_valid[CORE_LATENCY-1];
    assign last_op    = r_op[CORE_LATENCY-1];

endmodule : arcrypt_issue_delay
`default_nettype wire

// File: rtl/arcrypt_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : arcrypt_result_buffer
// Description : Captures the crypto core result CORE_LATENCY cycles after
//               each issue and queues {op, result} in a first-word-fall-
//               through FIFO drained by a valid/ready consumer.
// Ports       : CLK, Reset         - clock, synchronous active-high reset
//               issue, issue_op    - issue strobe and op tag
//               core_out           - core result bus
//               out_ready          - consumer accepts the head entry
//               out_valid/data/op  - FIFO head
//               level, full        - occupancy
//               overflow           - sticky drop flag, cleared by ovf_clear
// Revision    : 1.0 - initial release
// ============================================================================
module arcrypt_result_buffer
    import arcrypt_pkg::*;
#(
    parameter int CORE_LATENCY = 2,
    parameter int DEPTH        = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     issue,
    input  logic [OP_W-1:0]          issue_op,
    input  logic [DATA_W-1:0]        core_out,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OP_W-1:0]          out_op,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic            w_last_valid;
    logic [OP_W-1:0] w_last_op;

    arcrypt_issue_delay #(
        .CORE_LATENCY (CORE_LATENCY)
    ) u_issue_delay (
        .clk        (CLK),
        .rst        (Reset),
        .in_valid   (issue),
        .in_op      (issue_op),
        .last_valid (w_last_valid),
        .last_op    (w_last_op)
    );

    arcrypt_entry_t   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    logic w_full;
    logic w_pop;
    logic w_wr_en;
    logic w_drop;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    // Pop is qualified by non-empty, so a write into an empty FIFO is never
    // popped in the same cycle.
    assign w_pop   = (r_level != '0) && out_ready;
    // A full FIFO still takes the write when the head leaves this cycle.
    assign w_wr_en = w_last_valid && (!w_full || w_pop);
    assign w_drop  = w_last_valid && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (w_wr_en && !Reset) begin
            r_mem[r_wr_ptr] <= '{op: w_last_op, data: core_out};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A new drop takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = (r_level != '0);
    assign out_data  = r_mem[r_rd_ptr].data;
    assign out_op    = r_mem[r_rd_ptr].op;
    assign level     = r_level;
    assign full      = w_full;
    assign overflow  = r_overflow;

endmodule : arcrypt_result_buffer
`default_nettype wire

// File: tb/tb_arcrypt_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arcrypt_result_buffer
// Description : Self-checking bench for arcrypt_result_buffer. A queue-based
//               reference model tracks issues by due cycle and the FIFO
//               contents as a queue of expected {op, data} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arcrypt_result_buffer;
    import arcrypt_pkg::*;

    localparam int CORE_LATENCY = 2;
    localparam int DEPTH        = 4;

    logic                   clk;
    logic                   rst;
    logic                   issue;
    logic [OP_W-1:0]        issue_op;
    logic [DATA_W-1:0]      core_out;
    logic                   out_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [OP_W-1:0]        out_op;
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   overflow;
    logic                   ovf_clear;

    arcrypt_result_buffer #(
        .CORE_LATENCY (CORE_LATENCY),
        .DEPTH        (DEPTH)
    ) dut (
        .CLK       (clk),
        .Reset     (rst),
        .issue     (issue),
        .issue_op  (issue_op),
        .core_out  (core_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_op    (out_op),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [OP_W-1:0] op;
    } pend_t;

    pend_t      pend[$];
    logic [11:0] exp_q[$];
    bit          exp_ovf;
    int          cyc;
    int          n_total;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the rules of the
    // buffer, clock the DUT and compare every observable output.
    task automatic tick(input bit iss, input logic [3:0] op, input logic [7:0] co,
                        input bit rdy, input bit clr, input bit rs);
        bit              wr;
        bit              pop;
        bit              drop;
        logic [OP_W-1:0] wop;
        issue     = iss;
        issue_op  = op;
        core_out  = co;
        out_ready = rdy;
        ovf_clear = clr;
        rst       = rs;
        wop       = '0;
        if (rs) begin
            exp_q.delete();
            pend.delete();
            exp_ovf = 1'b0;
        end else begin
            wr = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                wop = pend[0].op;
                wr  = 1'b1;
                void'(pend.pop_front());
            end
            pop  = (exp_q.size() > 0) && rdy;
            drop = wr && (exp_q.size() == DEPTH) && !pop;
            if (pop) void'(exp_q.pop_front());
            if (wr && !drop) exp_q.push_back({wop, co});
            if (drop) exp_ovf = 1'b1;
            else if (clr) exp_ovf = 1'b0;
            if (iss) pend.push_back('{due: cyc + CORE_LATENCY, op: op});
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_q.size() != 0) begin
            chk("data", 32'(out_data), 32'(exp_q[0][7:0]));
            chk("op", 32'(out_op), 32'(exp_q[0][11:8]));
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        cyc       = 0;
        exp_ovf   = 1'b0;
        issue     = 1'b0;
        issue_op  = '0;
        core_out  = '0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        rst       = 1'b1;

        // Reset state
        tick(0, 4'h0, 8'h00, 0, 0, 1);
        tick(0, 4'h0, 8'h00, 0, 0, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Single op: result lands CORE_LATENCY cycles after issue
        for (int i = 0; i <= CORE_LATENCY; i++)
            tick(i == 0, 4'h3, (i == CORE_LATENCY) ? 8'h2A : 8'h00, 0, 0, 0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h2A);
        chk("single_op", 32'(out_op), 32'h3);
        tick(0, 4'h0, 8'h00, 1, 0, 0);
        chk("single_pop_lvl", 32'(level), 32'd0);

        // Burst of 4 with consumer stalled, then drain
        for (int i = 0; i < 4 + CORE_LATENCY; i++)
            tick(i < 4, 4'(i), 8'(8'h10 + i - CORE_LATENCY), 0, 0, 0);
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_level", 32'(level), 32'd4);
        chk("burst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) tick(0, 4'h0, 8'h00, 1, 0, 0);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Overflow: fifth result is dropped
        for (int i = 0; i < 5 + CORE_LATENCY; i++)
            tick(i < 5, 4'(i), 8'(8'h10 + i - CORE_LATENCY), 0, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(out_data), 32'h10);
        tick(0, 4'h0, 8'h00, 0, 1, 0);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Simultaneous write and pop while full
        for (int i = 0; i <= CORE_LATENCY; i++)
            tick(i == 0, 4'hC, 8'h55, i == CORE_LATENCY, 0, 0);
        chk("simul_level", 32'(level), 32'd4);
        chk("simul_ovf", 32'(overflow), 32'd0);
        chk("simul_head", 32'(out_data), 32'h11);
        for (int i = 0; i < 5; i++) tick(0, 4'h0, 8'h00, 1, 0, 0);

        // Wrap: ten back-to-back issues with consumer always ready
        for (int i = 0; i < 10 + CORE_LATENCY + 2; i++)
            tick(i < 10, 4'(i), 8'(8'h80 + i - CORE_LATENCY), 1, 0, 0);
        chk("wrap_empty", 32'(level), 32'd0);

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 5 + CORE_LATENCY; i++)
            tick(i < 5, 4'(i), 8'(8'h40 + i),
                 0, i == 4 + CORE_LATENCY, 0);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        tick(0, 4'h0, 8'h00, 0, 0, 1);

        // Reset mid-flight discards the in-flight issue
        tick(0, 4'h0, 8'h00, 0, 0, 0);
        tick(1, 4'h7, 8'hEE, 0, 0, 0);
        tick(0, 4'h0, 8'hEE, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 4'h0, 8'hEE, 1, 0, 0);
            chk("midrst_level", 32'(level), 32'd0);
            chk("midrst_valid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 9) < 6, 4'($urandom), 8'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_arcrypt_result_buffer
`default_nettype wire
